// File: rtl/pl_io_walk_checker.sv
// Receiving end of the walking-one cable test: filters the {j13, j12} bus,
// checks each stable word against the one-hot rotation of the previous one, counts steps.
module pl_io_walk_checker #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 16,
    parameter int DEB_CYCLES    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       k2,
    input  logic [7:0] j12,
    input  logic [1:0] j13,
    output logic [2:0] j11_led,
    output logic       locked,
    output logic       error_flag,
    output logic [7:0] pass_cnt,
    output logic [7:0] err_cnt
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {HUNT, TRACK} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic onehot(input logic [WIDTH-1:0] w);
        return (w != '0) && ((w & (w - 1'b1)) == '0);
    endfunction

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], w[WIDTH-1]};
    endfunction

    logic [WIDTH-1:0] din_raw;
    assign din_raw = {j13, j12};

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  din_p0_q, din_p0_d, din_p1_q, din_p1_d;
    logic [WIDTH-1:0]  prev_q, prev_d, last_word_q, last_word_d, expected_q, expected_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              k2_p0_q, k2_p0_d, k2_p1_q, k2_p1_d;
    logic              k2_prev_q, k2_prev_d, k2_deb_q, k2_deb_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [7:0]        pass_cnt_q, pass_cnt_d, err_cnt_q, err_cnt_d;
    logic              error_flag_q, error_flag_d;
    logic [2:0]        led_ring_q, led_ring_d;
    logic              word_evt, k2_accept, clr;

    // Synchronizers, word stability filter and K2 debouncer
    always_comb begin
        din_p0_d = din_raw;
        din_p1_d = din_p0_q;
        prev_d   = din_p1_q;
        if (din_p1_q != prev_q)
            stab_cnt_d = '0;
        else
            stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 1'b1;
        // Requiring samp == prev stops a fresh change from riding a saturated count.
        word_evt    = (stab_cnt_q == STAB_MAX) && (din_p1_q == prev_q) && (din_p1_q != last_word_q);
        last_word_d = word_evt ? din_p1_q : last_word_q;

        k2_p0_d   = k2;
        k2_p1_d   = k2_p0_q;
        k2_prev_d = k2_p1_q;
        if (k2_p1_q != k2_prev_q)
            deb_cnt_d = '0;
        else
            deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 1'b1;
        k2_accept = (deb_cnt_q == DEB_MAX) && (k2_p1_q == k2_prev_q) && (k2_p1_q != k2_deb_q);
        k2_deb_d  = k2_accept ? k2_p1_q : k2_deb_q;
        clr       = k2_accept && !k2_p1_q;
    end

    // Walk checker; a clear on the same cycle as a word event discards the word
    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        pass_cnt_d   = pass_cnt_q;
        err_cnt_d    = err_cnt_q;
        error_flag_d = error_flag_q;
        led_ring_d   = led_ring_q;
        if (clr) begin
            state_d      = HUNT;
            expected_d   = '0;
            pass_cnt_d   = '0;
            err_cnt_d    = '0;
            error_flag_d = 1'b0;
            led_ring_d   = 3'b001;
        end else if (word_evt) begin
            if (state_q == HUNT) begin
                if (onehot(din_p1_q)) begin
                    expected_d = rotl(din_p1_q);
                    state_d    = TRACK;
                end
            end else if (din_p1_q == expected_q) begin
                pass_cnt_d = sat_inc(pass_cnt_q);
                expected_d = rotl(din_p1_q);
                led_ring_d = {led_ring_q[1:0], led_ring_q[2]};
            end else begin
                err_cnt_d    = sat_inc(err_cnt_q);
                error_flag_d = 1'b1;
                if (onehot(din_p1_q))
                    expected_d = rotl(din_p1_q);
                else
                    state_d = HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_p0_q     <= '0;
            din_p1_q     <= '0;
            prev_q       <= '0;
            stab_cnt_q   <= '0;
            last_word_q  <= '0;
            k2_p0_q      <= 1'b1;
            k2_p1_q      <= 1'b1;
            k2_prev_q    <= 1'b1;
            k2_deb_q     <= 1'b1;
            deb_cnt_q    <= '0;
            state_q      <= HUNT;
            expected_q   <= '0;
            pass_cnt_q   <= '0;
            err_cnt_q    <= '0;
            error_flag_q <= 1'b0;
            led_ring_q   <= 3'b001;
        end else begin
            din_p0_q     <= din_p0_d;
            din_p1_q     <= din_p1_d;
            prev_q       <= prev_d;
            stab_cnt_q   <= stab_cnt_d;
            last_word_q  <= last_word_d;
            k2_p0_q      <= k2_p0_d;
            k2_p1_q      <= k2_p1_d;
            k2_prev_q    <= k2_prev_d;
            k2_deb_q     <= k2_deb_d;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            expected_q   <= expected_d;
            pass_cnt_q   <= pass_cnt_d;
            err_cnt_q    <= err_cnt_d;
            error_flag_q <= error_flag_d;
            led_ring_q   <= led_ring_d;
        end
    end

    assign j11_led    = error_flag_q ? 3'b111 : led_ring_q;
    assign locked     = (state_q == TRACK);
    assign error_flag = error_flag_q;
    assign pass_cnt   = pass_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pl_io_walk_checker.sv
// Bench for pl_io_walk_checker: directed walk, glitch, clear and reset scenarios
// plus randomized words against a word-level reference model.
module tb_pl_io_walk_checker;

    localparam int STAB = 16;
    localparam int DEB  = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       k2;
    logic [9:0] din;
    logic [7:0] j12;
    logic [1:0] j13;
    logic [2:0] j11_led;
    logic       locked;
    logic       error_flag;
    logic [7:0] pass_cnt;
    logic [7:0] err_cnt;

    assign j12 = din[7:0];
    assign j13 = din[9:8];

    always #5 clk = ~clk;

    pl_io_walk_checker #(
        .WIDTH(10),
        .STABLE_CYCLES(STAB),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .k2(k2),
        .j12(j12),
        .j13(j13),
        .j11_led(j11_led),
        .locked(locked),
        .error_flag(error_flag),
        .pass_cnt(pass_cnt),
        .err_cnt(err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model, one step per accepted stable word
    bit         m_locked;
    logic [9:0] m_exp;
    logic [9:0] m_last;
    int         m_pass;
    int         m_err;
    bit         m_flag;
    int         m_led_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] next_of(input logic [9:0] w);
        int v;
        v = int'(w) * 2;
        if (v >= 1024) v = v - 1024 + 1;
        return 10'(v);
    endfunction

    task automatic model_clear();
        m_locked  = 1'b0;
        m_exp     = '0;
        m_pass    = 0;
        m_err     = 0;
        m_flag    = 1'b0;
        m_led_idx = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_last = '0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
        m_flag = 1'b1;
    endtask

    task automatic model_word(input logic [9:0] w);
        if (w == m_last) return;
        m_last = w;
        if (!m_locked) begin
            if ($countones(w) == 1) begin
                m_locked = 1'b1;
                m_exp    = next_of(w);
            end
        end else if (w == m_exp) begin
            if (m_pass < 255) m_pass++;
            m_exp     = next_of(w);
            m_led_idx = (m_led_idx + 1) % 3;
        end else if ($countones(w) == 1) begin
            model_err();
            m_exp = next_of(w);
        end else begin
            model_err();
            m_locked = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] led_exp;
        led_exp = m_flag ? 3'b111 : 3'(1 << m_led_idx);
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".pass_cnt"}, 32'(pass_cnt), m_pass);
        chk({tag, ".err_cnt"}, 32'(err_cnt), m_err);
        chk({tag, ".error_flag"}, 32'(error_flag), 32'(m_flag));
        chk({tag, ".j11_led"}, 32'(j11_led), 32'(led_exp));
    endtask

    task automatic hold_word(input string tag, input logic [9:0] w, input int n);
        din = w;
        repeat (n) @(negedge clk);
        model_word(w);
        check_all(tag);
    endtask

    task automatic glitch(input logic [9:0] w, input int n);
        din = w;
        repeat (n) @(negedge clk);
    endtask

    task automatic press_clear(input string tag);
        k2 = 1'b0;
        repeat (DEB + 10) @(negedge clk);
        model_clear();
        check_all({tag, ".press"});
        k2 = 1'b1;
        repeat (DEB + 10) @(negedge clk);
        check_all({tag, ".release"});
    endtask

    // Aligns the debounced press with the acceptance of word w
    task automatic clear_with_word(input string tag, input logic [9:0] w);
        k2 = 1'b0;
        repeat (DEB - STAB) @(negedge clk);
        din = w;
        repeat (60) @(negedge clk);
        model_clear();
        m_last = w;
        check_all({tag, ".coincide"});
        k2 = 1'b1;
        repeat (DEB + 10) @(negedge clk);
        check_all({tag, ".after"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] w;
        int         r;
        rst_n = 1'b0;
        k2    = 1'b1;
        din   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        hold_word("lock001", 10'h001, 40);
        w = 10'h001;
        for (int i = 0; i < 10; i++) begin
            w = next_of(w);
            hold_word("walk", w, 40);
        end
        chk("walk.final_pass", 32'(pass_cnt), 10);
        chk("walk.final_led", 32'(j11_led), 3'b010);

        hold_word("pre_glitch", 10'h002, 40);
        hold_word("pre_glitch", 10'h004, 40);
        glitch(10'h3FF, 5);
        hold_word("after_glitch", 10'h008, 40);
        hold_word("skip", 10'h020, 40);
        chk("skip.led", 32'(j11_led), 3'b111);
        hold_word("resync", 10'h040, 40);

        hold_word("zero", 10'h000, 40);
        chk("zero.locked", 32'(locked), 0);
        hold_word("relock", 10'h080, 40);

        press_clear("clear1");
        hold_word("post_clear", 10'h002, 40);
        clear_with_word("clear2", 10'h004);
        hold_word("static", 10'h004, 40);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: w = m_locked ? m_exp : 10'd1 << $urandom_range(0, 9);
                5:             w = 10'd1 << $urandom_range(0, 9);
                6:             w = 10'($urandom);
                7:             w = din;
                8: begin
                    w = din;
                    glitch(10'($urandom), $urandom_range(1, 8));
                end
                default:       w = '0;
            endcase
            hold_word("rand", w, $urandom_range(24, 40));
        end

        press_clear("clear3");
        hold_word("sat_lock", 10'h001, 40);
        for (int i = 0; i < 260; i++)
            hold_word("sat", m_exp, 24);
        chk("sat.pass_cnt", 32'(pass_cnt), 255);

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        hold_word("after_reset", din, 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
